// File: rtl/ex_mul_seq_if.sv
// Handshake and shared-ALU bus between the EX-stage multiply sequencer and its surroundings.
interface ex_mul_seq_if #(parameter int W = 32);
  logic         start;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic [W-1:0] alu_z;
  logic         alu_grant;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] product;

  modport master (
    output start, mcand, mplier, alu_z,
    input  alu_grant, alu_a, alu_b, alu_op, stall, busy, done, product
  );

  modport slave (
    input  start, mcand, mplier, alu_z,
    output alu_grant, alu_a, alu_b, alu_op, stall, busy, done, product
  );
endinterface

// File: rtl/ex_mul_seq.sv
// Shift-and-add multiply sequencer that borrows the shared EX ALU for W cycles
// and stalls the pipeline until the low W product bits are ready.
module ex_mul_seq #(
  parameter int         W      = 32,
  parameter logic [2:0] ADD_OP = 3'b010
) (
  input logic         clk,
  input logic         reset,
  ex_mul_seq_if.slave bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  m;
  logic [W-1:0]  q;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  product_r;
  logic          run;

  // Every partial sum goes through the shared ALU; alu_z is only trusted in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      m         <= '0;
      q         <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m     <= bus.mcand;
            q     <= bus.mplier;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= bus.alu_z;
          m   <= {m[W-2:0], 1'b0};
          q   <= {1'b0, q[W-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            product_r <= bus.alu_z;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign run = (state == RUN);

  assign bus.alu_grant = run;
  assign bus.busy      = run;
  assign bus.done      = (state == DONE);
  assign bus.alu_a     = run ? acc : '0;
  assign bus.alu_b     = (run && q[0]) ? m : '0;
  assign bus.alu_op    = ADD_OP;
  // Combinational so the issuing instruction freezes in the very cycle start is accepted.
  assign bus.stall     = ((state == IDLE) && bus.start) || run;
  assign bus.product   = product_r;
endmodule

// File: tb/tb_ex_mul_seq.sv
// Self-checking bench for ex_mul_seq: behavioural ALU, expected-product scoreboard,
// and per-scenario tasks covering latency, stall/grant windows, ignored start and reset abort.
module tb_ex_mul_seq;
  localparam int         W      = 32;
  localparam logic [2:0] ADD_OP = 3'b010;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [W-1:0] exp_q[$];

  ex_mul_seq_if #(.W(W)) bus ();

  ex_mul_seq #(.W(W), .ADD_OP(ADD_OP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Shared combinational ALU: adds on ADD_OP, anything else yields a recognisable wrong value.
  assign bus.alu_z = (bus.alu_op == ADD_OP) ? (bus.alu_a + bus.alu_b) : (bus.alu_a ^ bus.alu_b ^ 32'hDEAD_BEEF);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (bus.alu_grant !== 1'b0) begin failures++; $display("[TB] FAIL reset_grant: got %0b expected 0", bus.alu_grant); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %0b expected 0", bus.stall); end
    checks++; if (bus.alu_a !== '0) begin failures++; $display("[TB] FAIL reset_alu_a: got %0h expected 0", bus.alu_a); end
    checks++; if (bus.alu_b !== '0) begin failures++; $display("[TB] FAIL reset_alu_b: got %0h expected 0", bus.alu_b); end
    checks++; if (bus.product !== '0) begin failures++; $display("[TB] FAIL reset_product: got %0h expected 0", bus.product); end
    checks++; if (bus.alu_op !== ADD_OP) begin failures++; $display("[TB] FAIL reset_alu_op: got %0h expected %0h", bus.alu_op, ADD_OP); end
  endtask

  // One multiply with start pulsed for a single cycle; operands are scrambled right after acceptance.
  task automatic test_multiply(input logic [W-1:0] a, input logic [W-1:0] b, input bit zero_b);
    int stall_n, grant_n, done_n, done_k, bnz;
    logic [W-1:0] expv, got_exp;
    stall_n = 0; grant_n = 0; done_n = 0; done_k = -1; bnz = 0;
    expv    = a * b;
    got_exp = '0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    exp_q.push_back(expv);
    #1;
    if (bus.stall === 1'b1) stall_n++;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL start_cycle_busy: got %0b expected 0", bus.busy); end
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start  = 1'b0;
        bus.mcand  = $urandom;
        bus.mplier = $urandom;
      end
      #1;
      if (bus.stall === 1'b1) stall_n++;
      if (bus.alu_grant === 1'b1) begin
        grant_n++;
        if (bus.alu_b !== '0) bnz++;
      end
      if (bus.done === 1'b1) begin
        done_n++;
        done_k = k;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL product_unexpected: got %0h expected no done", bus.product);
        end else begin
          got_exp = exp_q.pop_front();
          if (bus.product !== got_exp) begin failures++; $display("[TB] FAIL product: got %0h expected %0h (a=%0h b=%0h)", bus.product, got_exp, a, b); end
        end
      end
      if (k == W + 3) begin
        checks++; if (bus.product !== expv) begin failures++; $display("[TB] FAIL product_held: got %0h expected %0h", bus.product, expv); end
      end
    end
    checks++; if (stall_n != W + 1) begin failures++; $display("[TB] FAIL stall_cycles: got %0d expected %0d", stall_n, W + 1); end
    checks++; if (grant_n != W) begin failures++; $display("[TB] FAIL grant_cycles: got %0d expected %0d", grant_n, W); end
    checks++; if (done_n != 1) begin failures++; $display("[TB] FAIL done_pulses: got %0d expected 1", done_n); end
    checks++; if (done_k != W + 1) begin failures++; $display("[TB] FAIL done_latency: got %0d expected %0d", done_k, W + 1); end
    if (zero_b) begin
      checks++; if (bnz != 0) begin failures++; $display("[TB] FAIL zero_alu_b: got %0d nonzero cycles expected 0", bnz); end
    end
    exp_q.delete();
  endtask

  // Start held high through an operation; mid-run operand change must not relatch.
  task automatic test_back_to_back();
    int d0, d1, done_n;
    logic [W-1:0] got_exp;
    d0 = -1; d1 = -1; done_n = 0;
    exp_q.delete();
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 3;
    bus.mplier = 5;
    exp_q.push_back(15);
    for (int k = 1; k <= 2 * W + 8; k++) begin
      @(negedge clk);
      if (k == 10) begin
        bus.mcand  = 9;
        bus.mplier = 9;
      end
      if (k == W + 2) exp_q.push_back(81);
      if (k == W + 3) bus.start = 1'b0;
      #1;
      if (k == W + 2) begin
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart_stall: got %0b expected 1", bus.stall); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_restart_idle: got %0b expected 0", bus.busy); end
      end
      if (bus.done === 1'b1) begin
        done_n++;
        if (done_n == 1) d0 = k;
        if (done_n == 2) d1 = k;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL b2b_product_unexpected: got %0h expected no done", bus.product);
        end else begin
          got_exp = exp_q.pop_front();
          if (bus.product !== got_exp) begin failures++; $display("[TB] FAIL b2b_product: got %0h expected %0h", bus.product, got_exp); end
        end
      end
    end
    checks++; if (done_n != 2) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_n); end
    checks++; if (d0 != W + 1) begin failures++; $display("[TB] FAIL b2b_first_done: got %0d expected %0d", d0, W + 1); end
    checks++; if (d1 != 2 * W + 3) begin failures++; $display("[TB] FAIL b2b_second_done: got %0d expected %0d", d1, 2 * W + 3); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int done_n;
    done_n = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 100;
    bus.mplier = 100;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 10) reset = 1'b1;
      #1;
      if (k == 5) begin
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_running: got %0b expected 1", bus.busy); end
      end
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("[TB] FAIL abort_stall: got %0b expected 0", bus.stall); end
    checks++; if (bus.alu_grant !== 1'b0) begin failures++; $display("[TB] FAIL abort_grant: got %0b expected 0", bus.alu_grant); end
    checks++; if (bus.product !== '0) begin failures++; $display("[TB] FAIL abort_product: got %0h expected 0", bus.product); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) done_n++;
    end
    checks++; if (done_n != 0) begin failures++; $display("[TB] FAIL abort_done: got %0d pulses expected 0", done_n); end
    checks++; if (bus.product !== '0) begin failures++; $display("[TB] FAIL abort_product_after: got %0h expected 0", bus.product); end
    test_multiply(4, 4, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      test_multiply($urandom, $urandom, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_multiply(6, 7, 1'b0);
    test_multiply(32'hFFFF_FFFF, 2, 1'b0);
    test_multiply(32'h8000_0000, 32'h8000_0000, 1'b0);
    test_multiply(32'h1234_5678, 0, 1'b1);
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_mul_seq.md
# ex_mul_seq

Iterative multiply sequencer for the execute stage. It borrows the shared EX-stage ALU for W cycles and computes the low W bits of an unsigned product by shift-and-add, using the ALU's add operation for every partial sum. While it runs, it stalls the pipeline. When the result is ready, it pulses `done` and hands the ALU back to the normal EX datapath.

## Interface

Parameters:
- `W`, default 32: operand, product and ALU width.
- `ADD_OP`, default 3'b010: ALU op code for add.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a multiply; sampled only in IDLE.
- `mcand`  in  W: multiplicand, latched on an accepted start.
- `mplier`  in  W: multiplier, latched on an accepted start.
- `alu_z`  in  W: ALU result, fed back from the shared ALU.
- `alu_grant`  out  1: 1 selects controller operands onto the ALU; 0 selects the pipeline operands.
- `alu_a`  out  W: ALU operand A.
- `alu_b`  out  W: ALU operand B.
- `alu_op`  out  3: ALU op code.
- `stall`  out  1: freezes the IF, ID and EX pipeline registers.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse, high in DONE.
- `product`  out  W: low W bits of mcand*mplier; valid while `done` is high, then held.

## Operation

Registers:
- `M` (W bits): shifted multiplicand.
- `Q` (W bits): shifted multiplier.
- `acc` (W bits): accumulator.
- `cnt` (clog2(W)+1 bits): iteration counter.
- `product_r` (W bits): drives `product`.
- FSM state.

FSM states and transitions:
- IDLE:
  - On `start`=1, load M=`mcand`, Q=`mplier`, acc=0, cnt=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - `alu_a`=acc, `alu_b`=(Q[0] ? M : 0), `alu_op`=`ADD_OP`.
  - acc <= `alu_z`.
  - M <= M<<1 (drop the MSB); Q <= Q>>1 (zero-fill).
  - cnt <= cnt+1.
  - When cnt==W-1, go to DONE and load `product_r` with `alu_z`.
- DONE: stay one cycle, then go to IDLE unconditionally.

Output rules:
- `alu_grant` = `busy` = (state==RUN).
- Outside RUN, `alu_a` = `alu_b` = 0 and `alu_op` = `ADD_OP`.
- `stall` = (state==IDLE & `start`) | (state==RUN). It is combinational so the issuing instruction freezes in the same cycle as the accepted start.
- `done` = (state==DONE).

Arithmetic:
- Unsigned; overflow beyond W bits is discarded.
- The iteration count is fixed at W. There is no early termination when Q reaches 0.

Boundary conditions:
- `start` in RUN or DONE is ignored: no relatch, no restart. The requester re-asserts `start` in IDLE.
- `start` held high continuously is accepted once per IDLE visit, so back-to-back multiplies are spaced W+2 cycles apart.
- Operand changes after acceptance have no effect.
- Asynchronous `reset` in any state:
  - State returns to IDLE immediately.
  - M, Q, acc, cnt and `product_r` clear to 0.
  - `done` is not pulsed for an aborted operation.
- `alu_z` is sampled only in RUN; its value in other states is don't-care.

## Timing

- Reset values:
  - `alu_grant`, `busy`, `done`, `stall` = 0 (`stall` stays 0 unless `start` is asserted).
  - `alu_a`, `alu_b`, `product` = 0.
  - `alu_op` = `ADD_OP`.
- Cycle sequence for a start accepted at edge E0 (start high in the IDLE cycle before E0):
  - `stall` is high in that cycle.
  - RUN occupies the W cycles following E0.
  - DONE is the cycle after that.
  - Latency is W+1 cycles from the accepting edge to the `done` cycle.
- `stall` is high from the start cycle through the last RUN cycle inclusive, and low in DONE. The frozen EX instruction captures `product` at the edge that ends the DONE cycle.
- The ALU is combinational. `alu_z` must settle within the same cycle as `alu_a`/`alu_b`; there is no pipelined ALU.
- `product` changes only at the RUN→DONE edge or on reset.

## Test plan

- Basic multiply: reset, then `mcand`=6, `mplier`=7, `start` for 1 cycle.
  - Required: `stall`=1 for 33 cycles.
  - Required: `done`=1 exactly one cycle, at cycle 33 after E0, with `product`=42.
  - Required: `alu_grant`=1 for exactly 32 cycles.
- Overflow: `mcand`=0xFFFFFFFF, `mplier`=2 → `product`=0xFFFFFFFE. `mcand`=0x80000000, `mplier`=0x80000000 → `product`=0.
- Zero operands: `mcand`=0x12345678, `mplier`=0 → still 32 RUN cycles, `product`=0, and every RUN cycle shows `alu_b`=0.
- Ignored start: assert `start` with 3×5 and hold it; at RUN cycle 10, change operands to 9×9 and pulse `start` again.
  - Required: result is 15.
  - Required: the next operation (still held `start`) begins at the IDLE cycle after DONE and yields 81.
- Reset mid-run: start 100×100, assert `reset` at RUN cycle 10.
  - Required: `busy`, `stall` and `alu_grant` drop immediately.
  - Required: no `done` pulse and `product`=0.
  - Required: a subsequent 4×4 returns 16.
- Random regression: 1000 random unsigned operand pairs. `product` must equal (a*b) mod 2^32, and `done` must occur exactly W+1 cycles after each accepting edge.
